// File: rtl/store_lane_buffer_pkg.sv
// Shared store opcodes and lane-alignment result type for the store write buffer.
package store_lane_buffer_pkg;

  // Store width opcodes as presented by the MEM stage.
  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_SB   = 2'b01,
    ST_SH   = 2'b10,
    ST_SW   = 2'b11
  } st_op_e;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned LANE_W    = 8;
  localparam int unsigned DATA_W    = NUM_LANES * LANE_W;

  // Narrowed store: byte enables, lane-replicated data, alignment verdict.
  typedef struct packed {
    logic [NUM_LANES-1:0] be;
    logic [DATA_W-1:0]    wdata;
    logic                 aligned;
  } lane_t;

endpackage

// File: rtl/store_lane_buffer_align.sv
// Combinational store narrowing: op + byte offset + data -> byte enables,
// replicated write data and an alignment flag.
module store_lane_align
  import store_lane_buffer_pkg::*;
(
  input  st_op_e      op,
  input  logic [1:0]  a,
  input  logic [31:0] d,
  output lane_t       lane
);

  // Replicate the low byte/half across the word and pick enables from the offset.
  always_comb begin
    lane = '0;
    case (op)
      ST_SB: begin
        lane.wdata   = {4{d[7:0]}};
        lane.be      = 4'b0001 << a;
        lane.aligned = 1'b1;
      end
      ST_SH: begin
        lane.wdata   = {2{d[15:0]}};
        lane.be      = a[1] ? 4'b1100 : 4'b0011;
        lane.aligned = ~a[0];
      end
      ST_SW: begin
        lane.wdata   = d;
        lane.be      = 4'b1111;
        lane.aligned = (a == 2'b00);
      end
      default: lane = '0;
    endcase
  end

endmodule

// File: rtl/store_lane_buffer.sv
// Store write buffer: narrows MEM-stage stores into byte lanes, queues them in
// a DEPTH-entry FIFO and drains the head to data memory over valid/ready.
// Misaligned stores are dropped and reported; loads to a pending word stall.
module store_lane_buffer
  import store_lane_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 32,
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned OW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          st_valid,
  input  logic [1:0]    st_op,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  output logic          st_ready,
  output logic          st_misalign,
  output logic [AW-1:0] st_bad_addr,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_stall,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  output logic [OW-1:0] occupancy
);

  lane_t lane;

  logic [AW-3:0] ent_waddr_q [DEPTH];
  logic [AW-3:0] ent_waddr_d [DEPTH];
  logic [3:0]    ent_be_q    [DEPTH];
  logic [3:0]    ent_be_d    [DEPTH];
  logic [31:0]   ent_wdata_q [DEPTH];
  logic [31:0]   ent_wdata_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          misalign_q, misalign_d;
  logic [AW-1:0] bad_addr_q, bad_addr_d;

  logic offer, full, accept, pop, buf_hit;
  logic unused_ld_offset;

  store_lane_align u_align (
    .op   (st_op_e'(st_op)),
    .a    (st_addr[1:0]),
    .d    (st_data),
    .lane (lane)
  );

  assign offer     = st_valid && (st_op_e'(st_op) != ST_NONE);
  assign full      = (occ_q == OW'(DEPTH));
  assign st_ready  = ~full;
  assign accept    = offer && st_ready && lane.aligned;
  assign mem_valid = (occ_q != '0);
  assign pop       = mem_valid && mem_ready;

  // Head entry drives the memory port; idle port presents zeros.
  assign mem_addr  = mem_valid ? {ent_waddr_q[rd_ptr_q], 2'b00} : '0;
  assign mem_be    = mem_valid ? ent_be_q[rd_ptr_q] : '0;
  assign mem_wdata = mem_valid ? ent_wdata_q[rd_ptr_q] : '0;
  assign occupancy = occ_q;

  assign st_misalign = misalign_q;
  assign st_bad_addr = bad_addr_q;

  // Word-granular hazard check against buffered entries and the incoming store.
  always_comb begin
    buf_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i] && (ent_waddr_q[i] == ld_addr[AW-1:2])) buf_hit = 1'b1;
    if (accept && (st_addr[AW-1:2] == ld_addr[AW-1:2])) buf_hit = 1'b1;
  end
  assign ld_stall = ld_valid && buf_hit;
  assign unused_ld_offset = ^ld_addr[1:0];

  // Next-state for FIFO storage, pointers, occupancy and misalign report.
  always_comb begin
    ent_waddr_d = ent_waddr_q;
    ent_be_d    = ent_be_q;
    ent_wdata_d = ent_wdata_q;
    vld_d       = vld_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    occ_d       = occ_q;
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PW'(1);
    end
    if (accept) begin
      ent_waddr_d[wr_ptr_q] = st_addr[AW-1:2];
      ent_be_d[wr_ptr_q]    = lane.be;
      ent_wdata_d[wr_ptr_q] = lane.wdata;
      vld_d[wr_ptr_q]       = 1'b1;
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end
    case ({accept, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
    misalign_d = offer && !lane.aligned;
    bad_addr_d = misalign_d ? st_addr : bad_addr_q;
  end

  // State registers; reset discards any buffered stores immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_waddr_q[i] <= '0;
        ent_be_q[i]    <= '0;
        ent_wdata_q[i] <= '0;
      end
      vld_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      misalign_q <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      ent_waddr_q <= ent_waddr_d;
      ent_be_q    <= ent_be_d;
      ent_wdata_q <= ent_wdata_d;
      vld_q       <= vld_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      misalign_q  <= misalign_d;
      bad_addr_q  <= bad_addr_d;
    end
  end

endmodule

// File: tb/tb_store_lane_buffer.sv
// Randomized + directed bench for store_lane_buffer against a queue-based model.
module tb_store_lane_buffer;
  import store_lane_buffer_pkg::*;

  localparam int DEPTH = 2;
  localparam int AW    = 32;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic          clk = 0, reset_n = 0;
  logic          st_valid = 0;
  logic [1:0]    st_op = 0;
  logic [AW-1:0] st_addr = 0;
  logic [31:0]   st_data = 0;
  logic          st_ready, st_misalign;
  logic [AW-1:0] st_bad_addr;
  logic          ld_valid = 0;
  logic [AW-1:0] ld_addr = 0;
  logic          ld_stall, mem_valid;
  logic          mem_ready = 0;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic [OW-1:0] occupancy;

  store_lane_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .st_valid(st_valid), .st_op(st_op), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready), .st_misalign(st_misalign), .st_bad_addr(st_bad_addr),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct { int unsigned waddr; logic [3:0] be; logic [31:0] wd; } ent_t;
  ent_t q[$];
  logic        exp_mis = 0;
  logic [31:0] exp_bad = 0;
  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h @%0t", name, act, exp, $time);
    end
  endtask

  // Spec-level narrowing: size in bytes, enables from offset, bytes repeated modulo size.
  function automatic int unsigned op_size(input logic [1:0] op);
    case (op) 2'b01: return 1; 2'b10: return 2; 2'b11: return 4; default: return 0; endcase
  endfunction

  function automatic ent_t narrow(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    ent_t e;
    int unsigned sz = op_size(op);
    int unsigned off = a % 4;
    e.waddr = a / 4;
    e.be = 4'(((1 << sz) - 1) << off);
    for (int k = 0; k < 4; k++) e.wd[8*k +: 8] = d[8*(k % sz) +: 8];
    return e;
  endfunction

  task automatic drive(input logic sv, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic lv, input logic [31:0] la,
                       input logic mr);
    st_valid = sv; st_op = op; st_addr = a; st_data = d;
    ld_valid = lv; ld_addr = la; mem_ready = mr;
  endtask

  // Compare DUT against model, then advance one clock and update the model.
  task automatic step();
    int unsigned sz;
    bit offer, aligned, accept, pop, hit;
    ent_t ne;
    #1;
    sz = op_size(st_op);
    offer = st_valid && sz != 0;
    aligned = offer && (st_addr % sz) == 0;
    accept = offer && aligned && q.size() < DEPTH;
    pop = q.size() != 0 && mem_ready;
    ne = narrow(st_op, st_addr, st_data);
    hit = accept && ne.waddr == ld_addr / 4;
    foreach (q[i]) if (q[i].waddr == ld_addr / 4) hit = 1;
    chk("st_ready", st_ready, q.size() < DEPTH);
    chk("occupancy", occupancy, q.size());
    chk("mem_valid", mem_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("mem_addr", mem_addr, q[0].waddr * 4);
      chk("mem_be", mem_be, q[0].be);
      chk("mem_wdata", mem_wdata, q[0].wd);
    end
    chk("st_misalign", st_misalign, exp_mis);
    chk("st_bad_addr", st_bad_addr, exp_bad);
    chk("ld_stall", ld_stall, ld_valid && hit);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (accept) q.push_back(ne);
    exp_mis = offer && !aligned;
    if (exp_mis) exp_bad = st_addr;
    @(negedge clk);
  endtask

  task automatic idle(input logic mr);
    drive(0, 2'b00, 0, 0, 0, 0, mr);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst mem_valid", mem_valid, 0);
    chk("rst occupancy", occupancy, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_be", mem_be, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst st_misalign", st_misalign, 0);
    chk("rst st_bad_addr", st_bad_addr, 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1;
    @(negedge clk);

    // sb at offset 3, drained immediately
    drive(1, 2'b01, 32'h1003, 32'h12345678, 0, 0, 1); step();
    idle(1);
    chk("sb mem_addr", mem_addr, 32'h1000);
    chk("sb mem_be", mem_be, 4'b1000);
    chk("sb mem_wdata", mem_wdata, 32'h78787878);
    chk("sb occupancy", occupancy, 1);
    step();
    chk("sb drained", occupancy, 0);

    // sh at offset 2, then sw behind it
    drive(1, 2'b10, 32'h2002, 32'hAABBCCDD, 0, 0, 0); step();
    chk("sh mem_be", mem_be, 4'b1100);
    chk("sh mem_wdata", mem_wdata, 32'hCCDDCCDD);
    drive(1, 2'b11, 32'h2000, 32'h1, 0, 0, 0); step();
    idle(1); step();
    chk("sw mem_be", mem_be, 4'b1111);
    chk("sw mem_wdata", mem_wdata, 32'h1);
    step();

    // misaligned sw
    drive(1, 2'b11, 32'h3001, 32'hDEAD, 0, 0, 1); step();
    idle(1);
    chk("mis pulse", st_misalign, 1);
    chk("mis addr", st_bad_addr, 32'h3001);
    chk("mis occupancy", occupancy, 0);
    step();
    chk("mis pulse end", st_misalign, 0);
    chk("mis addr held", st_bad_addr, 32'h3001);

    // backpressure with three sw offers
    drive(1, 2'b11, 32'h5000, 32'hA, 0, 0, 0); step();
    drive(1, 2'b11, 32'h5004, 32'hB, 0, 0, 0); step();
    drive(1, 2'b11, 32'h5008, 32'hC, 0, 0, 0); #1;
    chk("full st_ready", st_ready, 0);
    step();
    mem_ready = 1;
    chk("drain head A", mem_wdata, 32'hA);
    step();
    chk("drain head B", mem_wdata, 32'hB);
    step();
    idle(1);
    chk("drain head C", mem_wdata, 32'hC);
    chk("C occupancy", occupancy, 1);
    step();

    // load stall against buffered word
    drive(1, 2'b11, 32'h4000, 32'h5, 0, 0, 0); step();
    drive(0, 2'b00, 0, 0, 1, 32'h4002, 0); #1;
    chk("ld same word", ld_stall, 1);
    ld_addr = 32'h4004; #1;
    chk("ld other word", ld_stall, 0);
    drive(0, 2'b00, 0, 0, 0, 0, 1); step();
    drive(0, 2'b00, 0, 0, 1, 32'h4000, 1); #1;
    chk("ld after pop", ld_stall, 0);
    step();

    // reset while two entries are queued
    drive(1, 2'b11, 32'h6000, 32'h1, 0, 0, 0); step();
    drive(1, 2'b11, 32'h6004, 32'h2, 0, 0, 0); step();
    idle(0);
    chk("pre-rst occupancy", occupancy, 2);
    reset_n = 0; #1;
    chk("mid-rst mem_valid", mem_valid, 0);
    chk("mid-rst occupancy", occupancy, 0);
    q.delete(); exp_mis = 0; exp_bad = 0;
    @(negedge clk); @(negedge clk);
    reset_n = 1;
    @(negedge clk);

    // randomized traffic over a small address window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            32'h4000 + $urandom_range(0, 15), $urandom,
            $urandom_range(0, 1) != 0, 32'h4000 + $urandom_range(0, 15),
            $urandom_range(0, 9) < 6);
      step();
    end
    idle(1);
    for (int n = 0; n < 4; n++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
